// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's data-memory request interface.
// It accepts one request at a time. After WAIT_CYCLES wait states it performs the word access
// on an internal array and returns a one-cycle valid pulse with the load data.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   request    core starts an access (held by the core until valid)
//   we_re      1 = store, 0 = load
//   mask       byte enables, bit i selects lane [8i+7:8i]
//   address    byte address; word index = address[log2(DEPTH_WORDS)+1:2]
//   store_data lane-aligned write data
//   ready      a request can be accepted this cycle
//   valid      one-cycle response strobe
//   load_data  full read word (0 for write responses), held until the next response
//   err        (DMEM_BOUNDS_CHECK_EN only) address >= 4*DEPTH_WORDS, updated with valid
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN. Without it, out-of-range addresses alias
// modulo DEPTH_WORDS.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDRESS     = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic                  we_re,
  input  logic [3:0]            mask,
  input  logic [ADDRESS-1:0]    address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] load_data
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam bit          ZeroWait = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WaitLoad = ZeroWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [3:0]            mask_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  oor_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [IdxW-1:0]       in_idx;
  logic                  in_oor;
  logic                  accept;
  logic                  fire;
  logic                  acc_we;
  logic [3:0]            acc_mask;
  logic [IdxW-1:0]       acc_idx;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_oor;
  logic                  unused_addr;

  assign in_idx = address[IdxW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign in_oor      = (address >> (IdxW + 2)) != '0;
  assign unused_addr = ^address[1:0];
  assign err         = err_q;
`else
  assign in_oor      = 1'b0;
  assign unused_addr = ^{address[1:0], address[ADDRESS-1:IdxW+2], err_q};
`endif

  assign ready  = (state_q != StWait);
  assign valid  = (state_q == StResp);
  assign accept = request & ready;

  // With zero wait states the access happens on the acceptance edge itself, so it uses the
  // live inputs; otherwise it uses the fields captured at acceptance.
  assign fire     = rst & ((ZeroWait & accept) | ((state_q == StWait) & (cnt_q == 4'd0)));
  assign acc_we   = ZeroWait ? we_re      : we_q;
  assign acc_mask = ZeroWait ? mask       : mask_q;
  assign acc_idx  = ZeroWait ? in_idx     : idx_q;
  assign acc_data = ZeroWait ? store_data : data_q;
  assign acc_oor  = ZeroWait ? in_oor     : oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (ZeroWait) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      mask_q    <= 4'd0;
      idx_q     <= '0;
      data_q    <= '0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      load_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= we_re;
        mask_q <= mask;
        idx_q  <= in_idx;
        data_q <= store_data;
        oor_q  <= in_oor;
      end
      if (fire) begin
        err_q     <= acc_oor;
        load_data <= (acc_we || acc_oor) ? '0 : mem_q[acc_idx];
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (fire && acc_we && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory request interface; core is the initiator.
- Accepts one request at a time: request, we_re, mask, address, store data.
- After a programmable number of wait states, performs the word access on an internal array and returns a one-cycle valid pulse plus load data.
- Serves as the data memory model in the core testbench and as the template for the instruction-memory responder.

Parameters:
- DATA_WIDTH, 32, data word width in bits; must be 32.
- ADDRESS, 32, byte-address width.
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- WAIT_CYCLES, 1, wait states between acceptance and the response edge; 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-low reset; the block is in reset while rst=0.
- request  input  1  core asserts to start an access.
- we_re  input  1  1 = write (store), 0 = read (load).
- mask  input  4  byte enables; bit i selects byte lane i (bits 8i+7:8i).
- address  input  ADDRESS  byte address; word index = address[log2(DEPTH_WORDS)+1:2]; address[1:0] ignored.
- store_data  input  DATA_WIDTH  write data, already lane-aligned by the core.
- ready  output  1  block can accept a request in this cycle.
- valid  output  1  one-cycle response strobe; read data valid / write done.
- load_data  output  DATA_WIDTH  full read word; 0 for write responses.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, valid=0, load_data=0, wait counter=0.
  - Array contents are not reset.
  - Reset mid-access abandons the access; a pending write is not committed and no valid is issued.
- States: IDLE, WAIT, RESP.
- Acceptance: on a rising edge with request=1 and ready=1, capture we_re, mask, word index and store_data.
  - ready=1 in IDLE and RESP; ready=0 in WAIT.
  - request while ready=0 is ignored. The core holds request until valid, so it is re-sampled at the next RESP or IDLE.
- Transitions:
  - IDLE --accept, WAIT_CYCLES=0--> RESP
  - IDLE --accept, WAIT_CYCLES>0--> WAIT, counter loaded with WAIT_CYCLES-1
  - WAIT --counter=0--> RESP; otherwise decrement the counter
  - RESP --accept--> same as the IDLE accept transitions (back-to-back)
  - RESP --no accept--> IDLE
- Latency: valid is high for exactly the one cycle in RESP, WAIT_CYCLES+1 cycles after the acceptance edge. Maximum throughput is one access per WAIT_CYCLES+1 cycles.
- Access at the edge that enters RESP:
  - Write: for each i with mask[i]=1, array byte lane i takes store_data lane i; other lanes are unchanged; load_data<=0.
  - Write with mask=0000: no array change; valid still pulses.
  - Read: load_data<=array word, full 32 bits regardless of mask. Lane extraction and sign extension are the core's job.
- Read after write to the same word returns the updated data, because the array update happens at the write's RESP edge.
- load_data holds its value until the next response edge; valid=0 outside RESP.
- Address wrap: the index uses only the low bits, so addresses above the array size alias modulo DEPTH_WORDS (without the optional feature).

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: adds output err (1 bit, reset 0), valid in the same cycle as valid.
  - Access with address >= 4*DEPTH_WORDS sets err=1.
  - Out-of-range write: array unchanged.
  - Out-of-range read: load_data=0.
  - Timing and valid behaviour are unchanged.
- Not defined: no err port; addresses alias modulo DEPTH_WORDS as above.

Test Plan:
- Reset, then WAIT_CYCLES=1:
  - Write address 0x10, mask 1111, data 0xDEADBEEF -> valid high exactly 2 cycles after acceptance, load_data=0.
  - Then read address 0x10 -> load_data=0xDEADBEEF with valid.
- Byte mask: word 0x20 preset to 0x11223344; write mask 0100, data 0x00AA0000 -> read returns 0x11AA3344.
- Back-to-back, WAIT_CYCLES=0, request held high for 3 reads of 0x0, 0x4, 0x8 -> valid on 3 consecutive cycles with the correct words; ready stays 1.
- Busy drop, WAIT_CYCLES=3:
  - Accept read, pulse request again during WAIT -> second request ignored; exactly one valid, 4 cycles after acceptance.
- Reset mid-access: accept write 0x55555555 to 0x40 (old value 0x0), assert rst=0 during WAIT -> valid never asserts; after release, read 0x40 returns 0x0.
- Wrap/bounds, DEPTH_WORDS=1024, write to 0x1000:
  - Without DMEM_BOUNDS_CHECK_EN: the write aliases to 0x0.
  - With DMEM_BOUNDS_CHECK_EN: err=1 with valid and word 0x0 is unchanged.
